crc_stream_engine: RTL and testbench
====================================

# crc_stream_engine

Parametrised streaming CRC engine for the 802.11b PLCP/MPDU datapath; successor to the fixed 8-bit CRC-32 generator. Computes any CRC_W-bit LSB-first CRC over a valid/ready byte stream and passes the data through. In generate mode it appends the FCS after the last beat; in check mode it compares the final register against the residue. The block sits between the MAC framer and the scrambler/DSSS spreader on TX, and after the descrambler on RX.

## Interface
- DATA_W, 8: beat width; must divide CRC_W.
- CRC_W, 32: CRC width.
- POLY, 32'h04C11DB7: generator polynomial, normal form, implicit x^CRC_W.
- INIT, all ones: register value at start of frame.
- XOROUT, all ones: final XOR applied after bit reversal.
- RESIDUE, 32'hC704DD7B: raw register value after a good frame plus its FCS.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- fcs_append  in  1  sampled on the first beat of a frame; 1 selects generate mode, 0 selects check mode.
- s_valid / s_ready  in/out  1  input handshake.
- s_data  in  DATA_W  input beat; bit 0 is processed first.
- s_last  in  1  marks the final input beat.
- m_valid / m_ready  out/in  1  output handshake.
- m_data  out  DATA_W  output beat.
- m_last  out  1  marks the final output beat.
- crc_out  out  CRC_W  bit-reversed register XOR XOROUT.
- crc_done  out  1  one-cycle pulse when the frame CRC is final.
- crc_ok  out  1  raw register == RESIDUE; valid while crc_done is high.

## Operation
- States: S_DATA and S_FCS. Reset enters S_DATA.
- S_DATA:
  - s_ready = (!m_valid || m_ready).
  - Each accepted beat updates the register by DATA_W serial LFSR steps, unrolled combinationally.
  - On the first beat of a frame, INIT is used as the base instead of the held register. A start-of-frame flag is set at reset and after every last beat.
- Accepted beat with s_last:
  - Generate mode: enter S_FCS with beat counter 0. m_last is not asserted on the data beat.
  - Check mode: the beat goes out with m_last=1, and crc_done pulses.
- S_FCS:
  - s_ready=0.
  - Emits CRC_W/DATA_W beats of crc_out, LSB slice first, advancing on each m_valid && m_ready.
  - m_last=1 on the final FCS beat. crc_done pulses when that beat is loaded; return to S_DATA.
- The register holds its value between frames. crc_out is stable until the next frame's first beat is accepted.
- Reset mid-frame: the frame is abandoned. State goes to S_DATA, the register to INIT, the counter to 0; m_valid and crc_done go low. Nothing is flushed.
- Reset values:
  - m_valid=0, m_data=0, m_last=0, crc_done=0, crc_ok=0.
  - crc_out = reverse(INIT)^XOROUT (0x00000000 at defaults).

## Timing
- Single output register: a beat accepted in cycle N is presented on m_* from cycle N+1. Full throughput with m_ready held high.
- m_* hold stable while m_valid && !m_ready.
- crc_done and crc_ok are asserted in cycle N+1 after the last data beat (check mode) or after the FCS beat is loaded (generate mode).
- Back-to-back frames are allowed. A new first beat may be accepted in the cycle crc_done is high, and it restarts from INIT without a bubble.
- In generate mode the FCS adds exactly CRC_W/DATA_W output cycles when m_ready=1.

## Configuration
- CRC_APPEND_EN defined: the S_FCS state, beat counter and fcs_append port are built.
- CRC_APPEND_EN undefined:
  - fcs_append is ignored and tied off internally.
  - Every frame runs in check/pass-through mode; s_last maps directly to m_last.
  - crc_done pulses after the last beat. Output is bit-identical for check-mode traffic.

## Structure
- Package crc_stream_pkg holds:
  - the state enum (S_DATA, S_FCS);
  - the default CRC-32 constants (POLY, INIT, XOROUT, RESIDUE);
  - a function crc_step(reg, data, poly) doing the DATA_W-bit unrolled update;
  - a bit-reverse function.
- One sub-module, crc_lfsr_step: a combinational, parametrised next-state unit, so it can be reused by a later multi-lane variant.

## Test plan
- Generate mode, ASCII "123456789" as 9 beats, m_ready=1:
  - crc_out=0xCBF43926;
  - the output is 13 beats ending 26 39 F4 CB, with m_last on 0xCB.
- Check mode, the same 13 beats as input: crc_ok=1 with crc_done; raw register 0xC704DD7B.
- Check mode with one flipped bit in beat 3: crc_done=1, crc_ok=0.
- Random m_ready backpressure (50%) over 100 random frames: the output stream equals input plus FCS, with no loss or duplication and m_* stable while stalled.
- Back-to-back frames with no idle cycle: the second frame's CRC equals its standalone value.
- rst asserted mid-frame and during S_FCS:
  - next cycle m_valid=0 and crc_out=0x00000000;
  - the following frame's CRC is correct.

Source files
------------

// File: rtl/crc_stream_pkg.sv
// Shared types, default CRC-32 constants and bit-serial helpers for the streaming CRC engine.
package crc_stream_pkg;

    typedef enum logic {
        S_DATA = 1'b0,
        S_FCS  = 1'b1
    } state_t;

    // Helpers work on a fixed wide container so they serve any CRC_W/DATA_W up to this size.
    localparam int MAX_W = 64;

    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOROUT  = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

    // data_w serial LFSR steps, data bit 0 first, register kept in normal (MSB-feedback) form.
    function automatic logic [MAX_W-1:0] crc_step(input logic [MAX_W-1:0] crc,
                                                  input logic [MAX_W-1:0] data,
                                                  input logic [MAX_W-1:0] poly,
                                                  input int crc_w,
                                                  input int data_w);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] r;
        logic [MAX_W-1:0] din;
        logic [MAX_W-1:0] top;
        logic             fb;
        mask = (MAX_W'(1) << crc_w) - MAX_W'(1);
        r    = crc & mask;
        din  = data;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < data_w) begin
                top = r >> (crc_w - 1);
                fb  = top[0] ^ din[0];
                din = din >> 1;
                r   = (r << 1) & mask;
                if (fb) begin
                    r = r ^ (poly & mask);
                end
            end
        end
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] v, input int w);
        logic [MAX_W-1:0] src;
        logic [MAX_W-1:0] r;
        src = v;
        r   = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                r   = {r[MAX_W-2:0], src[0]};
                src = src >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// Combinational DATA_W-bit CRC next-state unit; one instance per lane.
module crc_lfsr_step
    import crc_stream_pkg::*;
#(
    parameter int               DATA_W = 8,
    parameter int               CRC_W  = 32,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC32_POLY)
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  crc_next
);

    assign crc_next = CRC_W'(crc_step(MAX_W'(crc_in), MAX_W'(data), MAX_W'(POLY), CRC_W, DATA_W));

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming LSB-first CRC engine with pass-through data and a single output register.
// Define CRC_APPEND_EN to build FCS generation (S_FCS state, beat counter, fcs_append use).
module crc_stream_engine
    import crc_stream_pkg::*;
#(
    parameter int               DATA_W  = 8,
    parameter int               CRC_W   = 32,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC32_POLY),
    parameter logic [CRC_W-1:0] INIT    = {CRC_W{1'b1}},
    parameter logic [CRC_W-1:0] XOROUT  = {CRC_W{1'b1}},
    parameter logic [CRC_W-1:0] RESIDUE = CRC_W'(CRC32_RESIDUE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fcs_append,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_done,
    output logic              crc_ok
);

    localparam int FCS_BEATS = CRC_W / DATA_W;
    localparam int CNT_W     = (FCS_BEATS > 1) ? $clog2(FCS_BEATS) : 1;

    state_t            state;
    state_t            state_next;
    logic              sof;
    logic [CRC_W-1:0]  crc_reg;
    logic [CRC_W-1:0]  crc_base;
    logic [CRC_W-1:0]  crc_next;
    logic [CRC_W-1:0]  ok_src;
    logic              out_open;
    logic              s_fire;
    logic              load;
    logic              load_last;
    logic              frame_end;
    logic [DATA_W-1:0] load_data;

    assign out_open = !m_valid || m_ready;
    assign s_ready  = (state == S_DATA) && out_open;
    assign s_fire   = s_valid && s_ready;
    assign crc_base = sof ? INIT : crc_reg;
    assign crc_out  = CRC_W'(bit_reverse(MAX_W'(crc_reg), CRC_W)) ^ XOROUT;

    crc_lfsr_step #(
        .DATA_W (DATA_W),
        .CRC_W  (CRC_W),
        .POLY   (POLY)
    ) u_step (
        .crc_in   (crc_base),
        .data     (s_data),
        .crc_next (crc_next)
    );

`ifdef CRC_APPEND_EN
    logic             mode;
    logic             gen_now;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // The mode is latched from the first beat and reused for the rest of the frame.
    assign gen_now = sof ? fcs_append : mode;
`else
    logic unused_fcs_append;
    assign unused_fcs_append = fcs_append;
`endif

    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_data  = s_data;
        load_last  = 1'b0;
        frame_end  = 1'b0;
        ok_src     = crc_next;
`ifdef CRC_APPEND_EN
        cnt_next   = cnt;
`endif
        case (state)
            S_DATA: begin
                if (s_fire) begin
                    load = 1'b1;
                    if (s_last) begin
`ifdef CRC_APPEND_EN
                        if (gen_now) begin
                            state_next = S_FCS;
                            cnt_next   = '0;
                        end else begin
                            load_last = 1'b1;
                            frame_end = 1'b1;
                        end
`else
                        load_last = 1'b1;
                        frame_end = 1'b1;
`endif
                    end
                end
            end
`ifdef CRC_APPEND_EN
            S_FCS: begin
                ok_src    = crc_reg;
                load_data = DATA_W'(crc_out >> (int'(cnt) * DATA_W));
                if (out_open) begin
                    load     = 1'b1;
                    cnt_next = cnt + 1'b1;
                    if (cnt == CNT_W'(FCS_BEATS - 1)) begin
                        load_last  = 1'b1;
                        frame_end  = 1'b1;
                        state_next = S_DATA;
                        cnt_next   = '0;
                    end
                end
            end
`endif
            default: state_next = S_DATA;
        endcase
    end

    // Output register stage: one beat of latency from input acceptance to m_*.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_DATA;
            sof      <= 1'b1;
            crc_reg  <= INIT;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_last   <= 1'b0;
            crc_done <= 1'b0;
            crc_ok   <= 1'b0;
`ifdef CRC_APPEND_EN
            mode     <= 1'b0;
            cnt      <= '0;
`endif
        end else begin
            state    <= state_next;
            crc_done <= frame_end;
            if (frame_end) begin
                crc_ok <= (ok_src == RESIDUE);
            end
            if (s_fire) begin
                crc_reg <= crc_next;
                sof     <= s_last;
`ifdef CRC_APPEND_EN
                mode    <= gen_now;
`endif
            end
`ifdef CRC_APPEND_EN
            cnt <= cnt_next;
`endif
            if (load) begin
                m_valid <= 1'b1;
                m_data  <= load_data;
                m_last  <= load_last;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Self-checking bench for crc_stream_engine: directed CRC-32 vectors plus random frames
// compared against a reflected, byte-wise CRC-32 reference model.
`timescale 1ns/1ps
module tb_crc_stream_engine;

`ifdef CRC_APPEND_EN
    localparam bit HAS_APPEND = 1'b1;
`else
    localparam bit HAS_APPEND = 1'b0;
`endif

    typedef struct { logic [7:0] data; logic last; logic gen; } in_beat_t;
    typedef struct { logic [7:0] data; logic last; } out_beat_t;
    typedef struct { logic [31:0] crc; logic ok; } done_t;
    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fcs_append = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [7:0]  m_data;
    logic        m_last;
    logic [31:0] crc_out;
    logic        crc_done;
    logic        crc_ok;

    in_beat_t  in_q[$];
    out_beat_t exp_q[$];
    done_t     done_q[$];

    int         n_checks = 0;
    int         n_errors = 0;
    logic       hold_chk = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic       hold_last = 1'b0;
    logic       s_took = 1'b0;

    always #5 clk = ~clk;

    crc_stream_engine dut (
        .clk        (clk),
        .rst        (rst),
        .fcs_append (fcs_append),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .crc_out    (crc_out),
        .crc_done   (crc_done),
        .crc_ok     (crc_ok)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reflected CRC-32 state (not complemented) over a byte sequence.
    function automatic logic [31:0] ref_state(input byte_q_t b);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return c;
    endfunction

    task automatic add_frame(input byte_q_t b, input bit gen, input logic [31:0] exp_crc,
                             input bit exp_ok);
        bit eff;
        in_beat_t ib;
        out_beat_t ob;
        done_t d;
        eff = gen && HAS_APPEND;
        foreach (b[i]) begin
            ib.data = b[i];
            ib.last = (i == b.size() - 1);
            ib.gen  = gen;
            in_q.push_back(ib);
            ob.data = b[i];
            ob.last = !eff && (i == b.size() - 1);
            exp_q.push_back(ob);
        end
        if (eff) begin
            for (int k = 0; k < 4; k++) begin
                ob.data = 8'(exp_crc >> (8 * k));
                ob.last = (k == 3);
                exp_q.push_back(ob);
            end
        end
        d.crc = exp_crc;
        d.ok  = exp_ok;
        done_q.push_back(d);
    endtask

    task automatic add_model_frame(input byte_q_t b, input bit gen);
        logic [31:0] c;
        c = ref_state(b);
        add_frame(b, gen, ~c, c == 32'hDEBB_20E3);
    endtask

    function automatic byte_q_t rand_bytes(input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    task automatic step_cycle(input bit rnd_ready, input bit rnd_idle);
        in_beat_t  beat;
        out_beat_t e;
        done_t     d;
        @(negedge clk);
        if (s_took) begin
            s_valid = 1'b0;
            s_took  = 1'b0;
        end
        if (!s_valid && in_q.size() > 0 && !(rnd_idle && $urandom_range(0, 3) == 0)) begin
            beat       = in_q.pop_front();
            s_valid    = 1'b1;
            s_data     = beat.data;
            s_last     = beat.last;
            fcs_append = beat.gen;
        end
        m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (hold_chk) begin
            check_val("stall_valid", m_valid, 1);
            check_val("stall_data", m_data, hold_data);
            check_val("stall_last", m_last, hold_last);
        end
        if (crc_done) begin
            if (done_q.size() == 0) begin
                check_val("spurious_done", crc_done, 0);
            end else begin
                d = done_q.pop_front();
                check_val("crc_out", crc_out, d.crc);
                check_val("crc_ok", crc_ok, d.ok);
            end
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check_val("extra_beat", m_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check_val("m_data", m_data, e.data);
                check_val("m_last", m_last, e.last);
            end
        end
        hold_chk  = m_valid && !m_ready;
        hold_data = m_data;
        hold_last = m_last;
        s_took    = s_valid && s_ready;
    endtask

    task automatic drain(input bit rnd_ready, input bit rnd_idle, output int cycles);
        cycles = 0;
        while (!(in_q.size() == 0 && (!s_valid || s_took) && exp_q.size() == 0) && cycles < 20000) begin
            step_cycle(rnd_ready, rnd_idle);
            cycles++;
        end
        check_val("beats_left", exp_q.size(), 0);
        check_val("done_left", done_q.size(), 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst     = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        m_ready = 1'b1;
        @(negedge clk);
        check_val({tag, "_m_valid"}, m_valid, 0);
        check_val({tag, "_m_data"}, m_data, 0);
        check_val({tag, "_m_last"}, m_last, 0);
        check_val({tag, "_crc_done"}, crc_done, 0);
        check_val({tag, "_crc_ok"}, crc_ok, 0);
        check_val({tag, "_crc_out"}, crc_out, 32'h0000_0000);
        check_val({tag, "_s_ready"}, s_ready, 1);
        rst = 1'b0;
        in_q.delete();
        exp_q.delete();
        done_q.delete();
        hold_chk = 1'b0;
        s_took   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish within 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t     f;
        byte_q_t     g;
        logic [31:0] c;
        int          cyc;
        int          total;
        bit          gen;

        do_reset("init");

        // "123456789": generate mode (pass-through check mode when appending is not built).
        f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        add_frame(f, 1'b1, 32'hCBF4_3926, 1'b0);
        drain(1'b0, 1'b0, cyc);

        // The same payload followed by its FCS checks good.
        g = f;
        g.push_back(8'h26);
        g.push_back(8'h39);
        g.push_back(8'hF4);
        g.push_back(8'hCB);
        add_frame(g, 1'b0, 32'h2144_DF1C, 1'b1);
        drain(1'b0, 1'b0, cyc);

        // One flipped bit in beat 3 must fail the check.
        g[3] = g[3] ^ 8'h10;
        add_frame(g, 1'b0, ~ref_state(g), 1'b0);
        drain(1'b0, 1'b0, cyc);

        // Random frames under 50% backpressure and random source idles.
        for (int fr = 0; fr < 100; fr++) begin
            f   = rand_bytes($urandom_range(1, 16));
            gen = 1'($urandom_range(0, 1));
            if (!(gen && HAS_APPEND) && $urandom_range(0, 1) == 1) begin
                c = ref_state(f);
                for (int k = 0; k < 4; k++) f.push_back(8'(~c >> (8 * k)));
            end
            add_model_frame(f, gen);
        end
        drain(1'b1, 1'b1, cyc);

        // Back-to-back frames with no idle and m_ready held high: no output bubbles.
        add_model_frame(rand_bytes(5), 1'b1);
        add_model_frame(rand_bytes(1), 1'b0);
        add_model_frame(rand_bytes(7), 1'b1);
        add_model_frame(rand_bytes(3), 1'b1);
        total = exp_q.size();
        drain(1'b0, 1'b0, cyc);
        check_val("b2b_cycles", cyc, total + 1);

        // Reset in the middle of a data frame, then a clean frame.
        add_model_frame(rand_bytes(8), 1'b0);
        for (int i = 0; i < 4; i++) step_cycle(1'b0, 1'b0);
        do_reset("mid");
        f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        add_frame(f, 1'b0, 32'hCBF4_3926, 1'b0);
        drain(1'b0, 1'b0, cyc);

        // Reset while the FCS is being emitted, then a fresh generate frame.
        add_model_frame(rand_bytes(3), 1'b1);
        for (int i = 0; i < 5; i++) step_cycle(1'b0, 1'b0);
        do_reset("fcs");
        add_model_frame(rand_bytes(6), 1'b1);
        drain(1'b1, 1'b0, cyc);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
